// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the status-flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_XOR = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_OR  = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MUL_BUSY = 2'b01,
        DONE     = 2'b10
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the issuing controller, the ALU and the consumer.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per multiply.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] step_acc;
    logic               last_step;

    // product is the accumulator after the current step, so the final step is visible
    // combinationally on the same edge the owner registers it.
    assign step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = busy_q && (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
            if (last_step) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = last_step;
    assign product = step_acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; single-cycle ops complete on the accept edge,
// MUL is handed to the iterative multiplier and completes WIDTH cycles later.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    alu_flags_t         flags_q, flags_d;

    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    assign bus.in_ready = (state_q == IDLE);
    assign accept       = bus.in_valid && (state_q == IDLE);
    assign mul_start    = accept && (bus.op == OP_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath; diff[WIDTH] is the borrow (a < b unsigned).
    always_comb begin
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        diff    = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (bus.op)
            OP_AND: alu_res = bus.a & bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_OR:  alu_res = bus.a | bus.b;
            OP_SHL: alu_res = bus.a << bus.b[SHW-1:0];
            OP_SHR: alu_res = bus.a >> bus.b[SHW-1:0];
            OP_MUL: alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MUL) begin
                        state_d = MUL_BUSY;
                    end else begin
                        state_d   = DONE;
                        result_d  = alu_res;
                        flags_d.z = (alu_res == '0);
                        flags_d.n = alu_res[WIDTH-1];
                        flags_d.c = alu_c;
                        flags_d.v = alu_v;
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_busy && mul_done) begin
                    state_d   = DONE;
                    result_d  = mul_product[WIDTH-1:0];
                    flags_d.z = (mul_product[WIDTH-1:0] == '0);
                    flags_d.n = mul_product[WIDTH-1];
                    flags_d.c = |mul_product[2*WIDTH-1:WIDTH];
                    flags_d.v = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.flag_z    = flags_q.z;
    assign bus.flag_n    = flags_q.n;
    assign bus.flag_c    = flags_q.c;
    assign bus.flag_v    = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: ops, flags, latency, backpressure and mid-MUL reset.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(
        .WIDTH (W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] get_flags();
        return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
    endfunction

    // Issue one op, measure cycles to out_valid (1 = the cycle after the accept edge),
    // check result/flags, then release with out_ready.
    task automatic run_op(input string tag, input op_e op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_res,
                          input logic [3:0] exp_flags, input int exp_lat);
        int   lat;
        logic ready_while_busy;
        check_eq({tag, " in_ready before"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.op       = OP_SUB;
        lat = 1;
        ready_while_busy = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            ready_while_busy |= bus.in_ready;
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " in_ready while busy"}, 32'(ready_while_busy), 32'd0);
        check_eq({tag, " result"}, 32'(bus.result), 32'(exp_res));
        check_eq({tag, " flags zncv"}, 32'(get_flags()), 32'(exp_flags));
        check_eq({tag, " in_ready in DONE"}, 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq({tag, " out_valid after ack"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, " in_ready after ack"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic seen_valid;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = OP_AND;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset result", 32'(bus.result), 32'd0);
        check_eq("reset flags", 32'(get_flags()), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("post-reset in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        //      tag        op      a      b      res    zncv     lat
        run_op("add1",  OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000, 1);
        run_op("and1",  OP_AND, 8'h01, 8'h02, 8'h00, 4'b1000, 1);
        run_op("xor1",  OP_XOR, 8'h01, 8'h02, 8'h03, 4'b0000, 1);
        run_op("sub1",  OP_SUB, 8'h01, 8'h02, 8'hFF, 4'b0110, 1);
        run_op("addv",  OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101, 1);
        run_op("addc",  OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010, 1);
        run_op("shl",   OP_SHL, 8'h81, 8'h09, 8'h02, 4'b0000, 1);
        run_op("shr",   OP_SHR, 8'h81, 8'h07, 8'h01, 4'b0000, 1);
        run_op("or",    OP_OR,  8'hF0, 8'h0F, 8'hFF, 4'b0100, 1);
        run_op("mul1",  OP_MUL, 8'h0F, 8'h11, 8'hFF, 4'b0100, 9);
        run_op("mul2",  OP_MUL, 8'h10, 8'h10, 8'h00, 4'b1010, 9);

        // Backpressure: SUB result held for 5 cycles while a stray in_valid is offered.
        bus.in_valid = 1'b1;
        bus.a        = 8'h01;
        bus.b        = 8'h02;
        bus.op       = OP_SUB;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("bp%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check_eq($sformatf("bp%0d result", i), 32'(bus.result), 32'hFF);
            check_eq($sformatf("bp%0d flags", i), 32'(get_flags()), 32'b0110);
            check_eq($sformatf("bp%0d in_ready", i), 32'(bus.in_ready), 32'd0);
            bus.in_valid = (i == 1);
            bus.a        = 8'h05;
            bus.b        = 8'h05;
            bus.op       = OP_ADD;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq("bp release out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("bp release in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        check_eq("bp stray not accepted", 32'(bus.out_valid), 32'd0);
        check_eq("bp result kept", 32'(bus.result), 32'hFF);

        // Reset three cycles into a MUL, asserted between clock edges.
        bus.in_valid = 1'b1;
        bus.a        = 8'h0F;
        bus.b        = 8'h11;
        bus.op       = OP_MUL;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid-mul rst out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid-mul rst result", 32'(bus.result), 32'd0);
        check_eq("mid-mul rst flags", 32'(get_flags()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("after rst in_ready", 32'(bus.in_ready), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            seen_valid |= bus.out_valid;
        end
        check_eq("no stale out_valid", 32'(seen_valid), 32'd0);
        check_eq("no stale result", 32'(bus.result), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered ALU with valid/ready handshakes on input and output, status flags, and an eight-operation opcode set.
- Opcodes 0-3 keep the existing AND/XOR/ADD/SUB encodings; four new operations are added, including a multi-cycle multiply.
- Sits between an operand-issuing controller and a result consumer that may apply backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 4..32.
- SHW, $clog2(WIDTH), derived; shift-amount width taken from B[SHW-1:0]; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  opcode (alu_pkg::op_e).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- flag_z  output  1  result == 0.
- flag_n  output  1  result[WIDTH-1].
- flag_c  output  1  carry / borrow / multiply-overflow (defined below).
- flag_v  output  1  signed overflow for ADD/SUB; 0 for all other ops.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; out_valid = 0; result = 0; all flags = 0; multiply counter cleared.
  - in_ready = 1 immediately after rst_n deasserts.
  - No handshake is recognised while rst_n is low.
- Reset mid-operation: an in-flight MUL or a held result is discarded; no out_valid pulse follows.
- Opcodes:
  - 000 AND.
  - 001 XOR.
  - 010 ADD.
  - 011 SUB (a - b).
  - 100 OR.
  - 101 SHL (a << b[SHW-1:0], zero fill).
  - 110 SHR (logical, zero fill).
  - 111 MUL (low WIDTH bits of unsigned a*b).
- Flag rules:
  - ADD: flag_c = carry out of bit WIDTH-1; flag_v = (a[msb]==b[msb]) && (result[msb]!=a[msb]).
  - SUB: flag_c = borrow, i.e. a < b unsigned; flag_v = (a[msb]!=b[msb]) && (result[msb]!=a[msb]).
  - MUL: flag_c = 1 if the upper WIDTH bits of the 2*WIDTH-bit product are nonzero.
  - Logic and shift ops: flag_c = 0, flag_v = 0.
  - flag_z and flag_n are always derived from the registered result.
- FSM states: IDLE, MUL_BUSY, DONE.
  - in_ready = (state == IDLE), decoded from the state register.
  - IDLE, handshake with op != MUL: result and flags registered on the same edge; next state DONE. out_valid rises 1 cycle after accept.
  - IDLE, handshake with op == MUL: latch a and b; counter = 0; next state MUL_BUSY.
  - MUL_BUSY: one shift-add step per cycle. After WIDTH steps, register result and flags and go to DONE. out_valid rises exactly WIDTH+1 cycles after the accept edge.
  - DONE: out_valid = 1; result and flags held stable. When out_ready = 1, out_valid clears on that edge and the next state is IDLE.
  - in_valid is ignored outside IDLE.
- Throughput: at most one operation per 2 cycles for non-MUL ops, and one per WIDTH+2 cycles for MUL.
- Arithmetic is modulo 2^WIDTH. Shift amounts use only b[SHW-1:0]; upper bits of b are ignored.
- The a, b and op inputs are sampled only on the accept edge. Later changes do not affect an in-flight operation.

Decomposition:
- alu_pkg holds:
  - typedef enum logic [2:0] op_e {OP_AND, OP_XOR, OP_ADD, OP_SUB, OP_OR, OP_SHL, OP_SHR, OP_MUL};
  - typedef enum logic [1:0] state_e {IDLE, MUL_BUSY, DONE};
  - the flag struct alu_flags_t {z, n, c, v}.
- One sub-module, alu_mul_iter:
  - WIDTH-parametrised iterative shift-add multiplier.
  - Ports: clk, rst_n, start, a, b, busy, done, product[2*WIDTH-1:0].
  - Handles the MUL_BUSY datapath; alu_seq owns the FSM and the output register.

Test Plan:
- WIDTH=8, ADD a=0x01 b=0x02; then AND, XOR, SUB on the same operands -> results 0x03, 0x00, 0x03, 0xFF. Each out_valid is 1 cycle after accept. SUB gives c=1, n=1.
- ADD 0x7F+0x01 -> 0x80, v=1, n=1, c=0. ADD 0xFF+0x01 -> 0x00, z=1, c=1, v=0.
- SHL a=0x81 b=0x09 (shift 1) -> 0x02. SHR a=0x81 b=0x07 -> 0x01. OR 0xF0|0x0F -> 0xFF with c=v=0.
- MUL 0x0F*0x11 -> 0xFF, c=0; out_valid exactly 9 cycles after accept; in_ready=0 throughout. MUL 0x10*0x10 -> 0x00, z=1, c=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> result and flags stable, in_ready=0, and a new in_valid pulse is not accepted. Raise out_ready -> out_valid drops next edge and in_ready=1.
- Assert rst_n low 3 cycles into a MUL -> out_valid=0, result=0 and flags=0 asynchronously. After release, in_ready=1 and no stale result appears.
